uart_byte_fifo: RTL and testbench

UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_byte_fifo.sv | 114 +++++++++++
 tb/tb_uart_byte_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART byte FIFO slice.
// Optional macro UART_BYTE_FIFO_CRLF_EN widens entries with a CR flag bit.
package uart_pkg;

  localparam int unsigned   BYTE_W         = 8;
  localparam logic [7:0]    ASCII_CR       = 8'h0D;
  localparam logic [7:0]    ASCII_LF       = 8'h0A;
  localparam int unsigned   DEFAULT_LGFLEN = 4;

`ifdef UART_BYTE_FIFO_CRLF_EN
  localparam int unsigned   ENTRY_W        = BYTE_W + 1;
`else
  localparam int unsigned   ENTRY_W        = BYTE_W;
`endif

  // Transmit phase: sending the head byte, or the LF that follows a flagged CR.
  typedef enum logic {
    TX_BYTE = 1'b0,
    TX_LF   = 1'b1
  } tx_phase_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous-write array with combinational read of the head address.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_LGFLEN,
  parameter int unsigned DW = BYTE_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between rxuartlite and txuartlite with one-cycle strobes and sticky overflow.
// Define UART_BYTE_FIFO_CRLF_EN to emit an LF after every received CR.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned LGFLEN = DEFAULT_LGFLEN
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_tx_busy,
  output logic              o_tx_stb,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow
);

  localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};

  logic [LGFLEN-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]    fill_q, fill_d;
  logic               stb_q;
  logic               ovf_q, ovf_d;
  logic               full, empty, stb, push, pop;
  logic [ENTRY_W-1:0] wdata, head;
  logic [BYTE_W-1:0]  tx_data;

`ifdef UART_BYTE_FIFO_CRLF_EN
  tx_phase_e phase_q, phase_d;
  assign wdata = {i_rx_data == ASCII_CR, i_rx_data};
`else
  assign wdata = i_rx_data;
`endif

  uart_fifo_mem #(
    .AW (LGFLEN),
    .DW (ENTRY_W)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign full  = (fill_q == DEPTH);
  assign empty = (fill_q == '0);

  always_comb begin
    // Strobe is gated by reset so nothing leaves the FIFO in the reset cycle.
    stb     = !i_reset && !empty && !i_tx_busy && !stb_q;
    pop     = stb;
    tx_data = head[BYTE_W-1:0];
`ifdef UART_BYTE_FIFO_CRLF_EN
    phase_d = phase_q;
    if (phase_q == TX_LF) begin
      tx_data = ASCII_LF;
    end
    // A flagged CR stays at the head until its trailing LF has been sent.
    if (stb) begin
      if (phase_q == TX_BYTE && head[BYTE_W]) begin
        phase_d = TX_LF;
        pop     = 1'b0;
      end else begin
        phase_d = TX_BYTE;
      end
    end
`endif
    push     = i_rx_stb && (!full || pop);
    ovf_d    = ovf_q || (i_rx_stb && full && !pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      stb_q    <= stb;
      ovf_q    <= ovf_d;
    end
  end

`ifdef UART_BYTE_FIFO_CRLF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= TX_BYTE;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign o_tx_stb   = stb;
  assign o_tx_data  = tx_data;
  assign o_fill     = fill_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: queue-based reference model plus directed scenarios.
module tb_uart_byte_fifo;

  localparam int LG    = 4;
  localparam int DEPTH = 16;
`ifdef UART_BYTE_FIFO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rx_stb, busy;
  logic [7:0]  rx_data;
  logic        o_tx_stb;
  logic [7:0]  o_tx_data;
  logic [LG:0] o_fill;
  logic        o_overflow;

  uart_byte_fifo #(.LGFLEN(LG)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx_stb   (rx_stb),
    .i_rx_data  (rx_data),
    .i_tx_busy  (busy),
    .o_tx_stb   (o_tx_stb),
    .o_tx_data  (o_tx_data),
    .o_fill     (o_fill),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stored bytes in arrival order, LF owed, last strobe, sticky overflow.
  logic [7:0] m_q[$];
  bit         m_lf   = 1'b0;
  bit         m_prev = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         chk_en = 1'b0;
  logic [7:0] tx_log[$];
  bit         exp_stb, removed;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_stb = !reset && (m_q.size() > 0) && !busy && !m_prev;
      chk("fill", 32'(o_fill), m_q.size());
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("tx_stb", 32'(o_tx_stb), 32'(exp_stb));
      if (exp_stb) chk("tx_data", 32'(o_tx_data), m_lf ? 32'h0A : 32'(m_q[0]));
      if (o_tx_stb === 1'b1) tx_log.push_back(o_tx_data);
      if (reset) begin
        m_q.delete();
        m_lf = 1'b0; m_prev = 1'b0; m_ovf = 1'b0;
      end else begin
        removed = 1'b0;
        if (exp_stb) begin
          if (CRLF && !m_lf && m_q[0] == 8'h0D) m_lf = 1'b1;
          else begin
            m_lf = 1'b0;
            removed = 1'b1;
          end
        end
        if (rx_stb) begin
          if (m_q.size() < DEPTH || removed) m_q.push_back(rx_data);
          else m_ovf = 1'b1;
        end
        if (removed) void'(m_q.pop_front());
        m_prev = exp_stb;
      end
    end
  end

  task automatic cyc(input bit s, input logic [7:0] d, input bit b, input bit r);
    @(posedge clk); #1;
    rx_stb = s; rx_data = d; busy = b; reset = r;
  endtask

  task automatic fill_busy(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 8'(i), 1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, b, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_stb = 1'b0; rx_data = 8'h00; busy = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2, 1'b0);
    @(negedge clk);
    chk("rst_fill", 32'(o_fill), 0);
    chk("rst_stb", 32'(o_tx_stb), 0);
    chk("rst_ovf", 32'(o_overflow), 0);

    // Single byte latency
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_stb", 32'(o_tx_stb), 1);
    chk("single_data", 32'(o_tx_data), 32'h41);
    chk("single_fill1", 32'(o_fill), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_fill0", 32'(o_fill), 0);

    // Burst while busy, then drain
    fill_busy(8'h30, 16);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("burst_fill", 32'(o_fill), 16);
    chk("burst_nostb", 32'(o_tx_stb), 0);
    tx_log.delete();
    idle(40, 1'b0);
    chk("burst_count", tx_log.size(), 16);
    for (int i = 0; i < tx_log.size() && i < 16; i++)
      chk("burst_order", 32'(tx_log[i]), 32'h30 + i);

    // Write coinciding with dequeue on a full FIFO
    fill_busy(8'h60, 16);
    tx_log.delete();
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("simul_fill", 32'(o_fill), 16);
    chk("simul_ovf", 32'(o_overflow), 0);
    idle(40, 1'b0);
    chk("simul_count", tx_log.size(), 17);
    if (tx_log.size() == 17) begin
      chk("simul_first", 32'(tx_log[0]), 32'h60);
      chk("simul_last", 32'(tx_log[16]), 32'h77);
    end

    // Overflow drop and sticky flag
    fill_busy(8'h20, 16);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovf_set", 32'(o_overflow), 1);
    chk("ovf_fill", 32'(o_fill), 16);
    tx_log.delete();
    idle(40, 1'b0);
    chk("ovf_count", tx_log.size(), 16);
    if (tx_log.size() == 16) chk("ovf_last", 32'(tx_log[15]), 32'h2F);
    chk("ovf_held", 32'(o_overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_clr", 32'(o_overflow), 0);

    // Reset mid-operation
    fill_busy(8'hA0, 5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_fill5", 32'(o_fill), 5);
    tx_log.delete();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_fill0", 32'(o_fill), 0);
    chk("mid_stb0", 32'(o_tx_stb), 0);
    idle(5, 1'b0);
    chk("mid_none_tx", tx_log.size(), 0);

    // CR handling
    cyc(1'b1, 8'h0D, 1'b1, 1'b0);
    cyc(1'b1, 8'h42, 1'b1, 1'b0);
    tx_log.delete();
    idle(12, 1'b0);
`ifdef UART_BYTE_FIFO_CRLF_EN
    chk("crlf_count", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("crlf_0", 32'(tx_log[0]), 32'h0D);
      chk("crlf_1", 32'(tx_log[1]), 32'h0A);
      chk("crlf_2", 32'(tx_log[2]), 32'h42);
    end
`else
    chk("cr_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("cr_0", 32'(tx_log[0]), 32'h0D);
      chk("cr_1", 32'(tx_log[1]), 32'h42);
    end
`endif

    // Randomized traffic in phases of varying transmitter load
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, 99) < 50,
            ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom),
            $urandom_range(0, 5) < ph + (ph % 2) * 2,
            $urandom_range(0, 299) == 0);
      end
    end
    idle(40, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
